// File: rtl/soc_system_pll_reset_seq_if.sv
// Handshake/status bundle between the system PLL sequencer and its surroundings.
// master: the sequencer (drives PLL reset and status); slave: PLL / reset fabric side.
interface soc_system_pll_reset_seq_if;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       fail;
  logic [2:0] state_o;
  logic [7:0] loss_cnt;

  modport master (
    input  pll_locked, relock_req,
    output pll_rst, sys_reset_n, fail, state_o, loss_cnt
  );

  modport slave (
    output pll_locked, relock_req,
    input  pll_rst, sys_reset_n, fail, state_o, loss_cnt
  );
endinterface

// File: rtl/soc_system_pll_reset_seq.sv
// System PLL bring-up sequencer and lock supervisor, clocked by the free-running refclk.
// Holds the PLL in reset, waits for a synchronised lock, requires lock to stay stable
// before releasing the downstream system reset, retries on timeout and re-sequences on
// loss of lock or a software relock request.
// Optional feature macro: PLL_SEQ_LOSS_CNT_EN (implements the saturating loss-of-lock
// counter; when undefined loss_cnt reads as zero).
module soc_system_pll_reset_seq #(
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  soc_system_pll_reset_seq_if.master bus
);

  localparam int unsigned MAX_AB = (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ?
                                   RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MAX_CD = (LOCK_TIMEOUT_CYCLES > MAX_RETRIES) ?
                                   LOCK_TIMEOUT_CYCLES : MAX_RETRIES;
  localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW     = $clog2(MAX_P) + 1;

  typedef enum logic [2:0] {
    ST_RESET_PLL = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] retry_cnt;
  logic [CW-1:0] retry_nxt;
  logic          sync_q;
  logic          lock_s;

  // Next-state and counter update; one shared counter serves hold, timeout and stable phases.
  always_comb begin
    nxt       = state;
    cnt_nxt   = cnt;
    retry_nxt = retry_cnt;
    case (state)
      ST_RESET_PLL: begin
        if (cnt == CW'(RST_HOLD_CYCLES - 1)) begin
          nxt     = ST_WAIT_LOCK;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          nxt     = ST_STABILIZE;
          cnt_nxt = '0;
        end else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1)) begin
          retry_nxt = retry_cnt + CW'(1);
          cnt_nxt   = '0;
          nxt       = (retry_nxt == CW'(MAX_RETRIES)) ? ST_FAIL : ST_RESET_PLL;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_STABILIZE: begin
        // A lock drop wins over a completing count.
        if (!lock_s) begin
          nxt     = ST_WAIT_LOCK;
          cnt_nxt = '0;
        end else if (cnt == CW'(LOCK_STABLE_CYCLES - 1)) begin
          nxt     = ST_RUN;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_RUN: begin
        retry_nxt = '0;
        if (!lock_s || bus.relock_req) begin
          nxt     = ST_RESET_PLL;
          cnt_nxt = '0;
        end
      end
      ST_FAIL: begin
        if (bus.relock_req) begin
          nxt       = ST_RESET_PLL;
          cnt_nxt   = '0;
          retry_nxt = '0;
        end
      end
      default: begin
        nxt     = ST_RESET_PLL;
        cnt_nxt = '0;
      end
    endcase
  end

  // State, counters, lock synchroniser and outputs decoded from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q          <= 1'b0;
      lock_s          <= 1'b0;
      state           <= ST_RESET_PLL;
      cnt             <= '0;
      retry_cnt       <= '0;
      bus.pll_rst     <= 1'b1;
      bus.sys_reset_n <= 1'b0;
      bus.fail        <= 1'b0;
      bus.state_o     <= 3'd0;
    end else begin
      sync_q          <= bus.pll_locked;
      lock_s          <= sync_q;
      state           <= nxt;
      cnt             <= cnt_nxt;
      retry_cnt       <= retry_nxt;
      bus.pll_rst     <= (nxt == ST_RESET_PLL) || (nxt == ST_FAIL);
      bus.sys_reset_n <= (nxt == ST_RUN);
      bus.fail        <= (nxt == ST_FAIL);
      bus.state_o     <= 3'(nxt);
    end
  end

`ifdef PLL_SEQ_LOSS_CNT_EN
  logic [7:0] loss_q;
  logic       loss_evt;

  // A lock drop in RUN counts as a loss even when a relock request arrives together.
  assign loss_evt = (state == ST_RUN) && !lock_s;

  // Saturating loss-of-lock event counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      loss_q <= 8'd0;
    end else if (loss_evt && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign bus.loss_cnt = loss_q;
`else
  assign bus.loss_cnt = 8'd0;
`endif

endmodule
